// File: rtl/ps2_scancode_receiver.sv
// PS/2 device-to-host receiver: sync, clock glitch filter, framing checks,
// E0/F0 prefix folding and a fall-through FIFO of decoded keys.
module ps2_scancode_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] code,
    output logic       is_break,
    output logic       is_extended,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic [FW-1:0]          flt_cnt;
    logic                   flt_clk;
    logic                   flt_prev;
    logic                   fe;
    logic                   din;
    logic                   clk_s;

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign din   = dat_sync[SYNC_STAGES-1];
    assign fe    = flt_prev & ~flt_clk;

    // Filtered clock only follows after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
            flt_clk  <= 1'b1;
            flt_prev <= 1'b1;
            flt_cnt  <= '0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            flt_prev <= flt_clk;
            if (clk_s == flt_clk) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FMAX) begin
                flt_clk <= clk_s;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    state_t        state, state_n;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tcnt;
    logic          ext, brk;
    logic          timeout;
    logic          accept, perr, ferr;

    assign timeout = (state != IDLE) && !fe && (tcnt == TMAX);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        perr    = 1'b0;
        ferr    = 1'b0;
        if (fe) begin
            unique case (state)
                IDLE: begin
                    if (!din) state_n = DATA;
                    else      ferr    = 1'b1;
                end
                DATA: begin
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: state_n = STOP;
                STOP: begin
                    state_n = IDLE;
                    if (!din)               ferr   = 1'b1;
                    else if (!(^{shreg, par})) perr = 1'b1;
                    else                    accept = 1'b1;
                end
            endcase
        end else if (timeout) begin
            state_n = IDLE;
            ferr    = 1'b1;
        end
    end

    logic push, pop, full, do_push;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;

    assign push    = accept && shreg != 8'hE0 && shreg != 8'hF0;
    assign valid   = count != '0;
    assign pop     = valid && ready;
    assign full    = count == FULL;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tcnt       <= '0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state <= state_n;
            if (fe || state == IDLE) tcnt <= '0;
            else if (tcnt != TMAX)   tcnt <= tcnt + TW'(1);
            if (fe && state == IDLE) bit_cnt <= '0;
            if (fe && state == DATA) begin
                shreg   <= {din, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (fe && state == PARITY) par <= din;
            if (ferr || perr) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (accept) begin
                ext <= shreg == 8'hE0 ? 1'b1 : (shreg == 8'hF0 ? ext : 1'b0);
                brk <= shreg == 8'hF0 ? 1'b1 : (shreg == 8'hE0 ? brk : 1'b0);
            end
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !pop)      count <= count + (AW + 1)'(1);
            else if (!do_push && pop) count <= count - (AW + 1)'(1);
            parity_err <= perr;
            frame_err  <= ferr;
            overflow   <= push && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {ext, brk, shreg};
    end

    assign code        = valid ? mem[rd_ptr][7:0] : 8'h00;
    assign is_break    = valid & mem[rd_ptr][8];
    assign is_extended = valid & mem[rd_ptr][9];
endmodule
